// File: rtl/rx_pattern_gen.sv
// rx_pattern_gen: per-strobe selection between live RX samples and
// deterministic test patterns (counter, ramp, constant, LFSR), configured
// through three consecutive settings-bus registers.
module rx_pattern_gen #(
  parameter int         NCHAN   = 2,
  parameter int         WIDTH   = 16,
  parameter logic [6:0] SR_BASE = 7'd80
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     enable,
  input  logic                     strobe,
  input  logic [NCHAN*WIDTH-1:0]   in_data,
  input  logic [6:0]               serial_addr,
  input  logic [31:0]              serial_data,
  input  logic                     serial_strobe,
  output logic [NCHAN*WIDTH-1:0]   out_data,
  output logic                     out_strobe,
  output logic [2:0]               mode
);

  localparam logic [2:0]  MODE_PASS  = 3'd0;
  localparam logic [2:0]  MODE_COUNT = 3'd1;
  localparam logic [2:0]  MODE_RAMP  = 3'd2;
  localparam logic [2:0]  MODE_CONST = 3'd3;
  localparam logic [2:0]  MODE_LFSR  = 3'd4;
  localparam logic [15:0] LFSR_MASK  = 16'hB400;

  // Configuration registers
  logic [2:0]             mode_q,  mode_d;
  logic [WIDTH-1:0]       value_q, value_d;
  logic [WIDTH-1:0]       step_q,  step_d;

  // Pattern generator state
  logic [WIDTH-1:0]       base_q,  base_d;
  logic [WIDTH-1:0]       acc_q,   acc_d;
  logic [15:0]            lfsr_q,  lfsr_d;

  // Output stage
  logic [NCHAN*WIDTH-1:0] out_data_q, out_data_d;
  logic                   out_strobe_q, out_strobe_d;

  // Per-cycle effective generator state (post-initialisation)
  logic                   wr0, wr1, wr2;
  logic                   init;
  logic [15:0]            seed;
  logic [WIDTH-1:0]       cur_base;
  logic [WIDTH-1:0]       cur_acc;
  logic [15:0]            cur_lfsr;
  logic [15:0]            lfsr_adv;
  logic [WIDTH-1:0]       gen_chan [NCHAN];
  logic [NCHAN*WIDTH-1:0] gen_data;

  // Settings-bus decode, register updates and generator initialisation
  always_comb begin
    wr0 = serial_strobe && (serial_addr == SR_BASE);
    wr1 = serial_strobe && (serial_addr == 7'(SR_BASE + 7'd1));
    wr2 = serial_strobe && (serial_addr == 7'(SR_BASE + 7'd2));

    mode_d  = mode_q;
    value_d = value_q;
    step_d  = step_q;
    if (wr0) mode_d  = serial_data[2:0];
    if (wr1) value_d = serial_data[WIDTH-1:0];
    if (wr2) step_d  = serial_data[WIDTH-1:0];

    // Initialisation uses the freshly written configuration so that a
    // write coinciding with a strobe already produces the new pattern.
    init     = !enable || wr0 || wr1 || wr2;
    seed     = (value_d[15:0] == 16'h0000) ? 16'h0001 : value_d[15:0];
    cur_base = init ? '0      : base_q;
    cur_acc  = init ? value_d : acc_q;
    cur_lfsr = init ? seed    : lfsr_q;
    lfsr_adv = (cur_lfsr >> 1) ^ (cur_lfsr[0] ? LFSR_MASK : 16'h0000);
  end

  // Per-channel pattern selection; modes 5..7 fall back to pass-through
  genvar gi;
  generate
    for (gi = 0; gi < NCHAN; gi++) begin : g_chan
      assign gen_chan[gi] =
        (mode_d == MODE_COUNT) ? WIDTH'(cur_base + WIDTH'(gi)) :
        (mode_d == MODE_RAMP)  ? cur_acc :
        (mode_d == MODE_CONST) ? value_d :
        (mode_d == MODE_LFSR)  ? WIDTH'(WIDTH'(cur_lfsr) + WIDTH'(gi)) :
                                 in_data[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // Pack channels and compute generator advance and output next-state
  always_comb begin
    gen_data = '0;
    for (int k = 0; k < NCHAN; k++) begin
      gen_data[k*WIDTH +: WIDTH] = gen_chan[k];
    end

    base_d = cur_base;
    acc_d  = cur_acc;
    lfsr_d = cur_lfsr;
    // An initialising cycle outputs the fresh state but never advances it.
    if (strobe && !init) begin
      case (mode_d)
        MODE_COUNT: base_d = cur_base + WIDTH'(NCHAN);
        MODE_RAMP:  acc_d  = cur_acc + step_d;
        MODE_LFSR:  lfsr_d = lfsr_adv;
        default:    ;
      endcase
    end

    out_data_d   = strobe ? gen_data : out_data_q;
    out_strobe_d = strobe;
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      mode_q       <= MODE_PASS;
      value_q      <= '0;
      step_q       <= WIDTH'(1);
      base_q       <= '0;
      acc_q        <= '0;
      lfsr_q       <= 16'h0001;
      out_data_q   <= '0;
      out_strobe_q <= 1'b0;
    end else begin
      mode_q       <= mode_d;
      value_q      <= value_d;
      step_q       <= step_d;
      base_q       <= base_d;
      acc_q        <= acc_d;
      lfsr_q       <= lfsr_d;
      out_data_q   <= out_data_d;
      out_strobe_q <= out_strobe_d;
    end
  end

  assign out_data   = out_data_q;
  assign out_strobe = out_strobe_q;
  assign mode       = mode_q;

endmodule

// File: tb/tb_rx_pattern_gen.sv
// Scoreboard bench for rx_pattern_gen (NCHAN=2, WIDTH=16).
module tb_rx_pattern_gen;

  localparam int         NCHAN   = 2;
  localparam int         WIDTH   = 16;
  localparam logic [6:0] SR_BASE = 7'd80;
  localparam int         DW      = NCHAN * WIDTH;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          enable;
  logic          strobe;
  logic [DW-1:0] in_data;
  logic [6:0]    serial_addr;
  logic [31:0]   serial_data;
  logic          serial_strobe;
  logic [DW-1:0] out_data;
  logic          out_strobe;
  logic [2:0]    mode;

  int n_cmp = 0;
  int n_bad = 0;
  logic bulk = 1'b0;

  logic [DW-1:0] exp_q [$];
  string         tag_q [$];

  rx_pattern_gen #(.NCHAN(NCHAN), .WIDTH(WIDTH), .SR_BASE(SR_BASE)) dut (
    .clock(clock), .reset_n(reset_n), .enable(enable), .strobe(strobe),
    .in_data(in_data), .serial_addr(serial_addr), .serial_data(serial_data),
    .serial_strobe(serial_strobe), .out_data(out_data),
    .out_strobe(out_strobe), .mode(mode)
  );

  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [63:0] got,
                           input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  // Monitor: every out_strobe pops one expected sample
  always @(negedge clock) begin
    if (out_strobe === 1'b1 && !bulk) begin
      if (exp_q.size() == 0) begin
        check_val("unexpected_out_strobe", 64'd1, 64'd0);
      end else begin
        check_val(tag_q.pop_front(), 64'(out_data), 64'(exp_q.pop_front()));
      end
    end
  end

  task automatic sr_write(input logic [6:0] addr, input logic [31:0] data);
    @(negedge clock);
    serial_strobe = 1'b1;
    serial_addr   = addr;
    serial_data   = data;
    @(negedge clock);
    serial_strobe = 1'b0;
  endtask

  // One strobe with expected output pushed to the scoreboard
  task automatic send(input string tag, input logic [DW-1:0] exp);
    @(negedge clock);
    strobe = 1'b1;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    @(negedge clock);
    strobe = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; enable = 1'b1; strobe = 1'b0; in_data = '0;
    serial_addr = '0; serial_data = '0; serial_strobe = 1'b0;
    repeat (3) @(negedge clock);
    check_val("reset_out_data", 64'(out_data), 64'd0);
    check_val("reset_out_strobe", 64'(out_strobe), 64'd0);
    check_val("reset_mode", 64'(mode), 64'd0);
    reset_n = 1'b1;

    // Counter mode
    sr_write(SR_BASE, 32'd1);
    check_val("mode_readback_1", 64'(mode), 64'd1);
    send("cnt0", {16'h0001, 16'h0000});
    send("cnt1", {16'h0003, 16'h0002});
    send("cnt2", {16'h0005, 16'h0004});

    // Counter wrap: reinitialise, run 0x7FFF strobes to reach base 0xFFFE
    sr_write(SR_BASE, 32'd1);
    @(negedge clock);
    bulk = 1'b1;
    strobe = 1'b1;
    repeat (32'h7FFF) @(negedge clock);
    strobe = 1'b0;
    @(negedge clock);
    bulk = 1'b0;
    send("cnt_wrap0", {16'hFFFF, 16'hFFFE});
    send("cnt_wrap1", {16'h0001, 16'h0000});
    @(negedge clock); enable = 1'b0;
    @(negedge clock); enable = 1'b1;
    send("cnt_after_disable", {16'h0001, 16'h0000});
    // Strobe while disabled: initialised state, no advance
    @(negedge clock); enable = 1'b0;
    send("cnt_disabled", {16'h0001, 16'h0000});
    enable = 1'b1;
    send("cnt_reenabled", {16'h0001, 16'h0000});

    // Ramp mode
    sr_write(SR_BASE + 7'd1, 32'h0010);
    sr_write(SR_BASE + 7'd2, 32'h0003);
    sr_write(SR_BASE, 32'd2);
    send("ramp0", {16'h0010, 16'h0010});
    send("ramp1", {16'h0013, 16'h0013});
    send("ramp2", {16'h0016, 16'h0016});
    sr_write(SR_BASE + 7'd2, 32'h0005);
    send("ramp_restart", {16'h0010, 16'h0010});
    send("ramp_step5", {16'h0015, 16'h0015});

    // Constant mode
    sr_write(SR_BASE, 32'd3);
    send("const0", {16'h0010, 16'h0010});
    send("const1", {16'h0010, 16'h0010});

    // LFSR mode, seed 1 then seed 0 (replaced by 1)
    sr_write(SR_BASE + 7'd1, 32'h0001);
    sr_write(SR_BASE, 32'd4);
    send("lfsr_s1_0", {16'h0002, 16'h0001});
    send("lfsr_s1_1", {16'hB401, 16'hB400});
    send("lfsr_s1_2", {16'h5A01, 16'h5A00});
    sr_write(SR_BASE + 7'd1, 32'h0000);
    send("lfsr_s0_0", {16'h0002, 16'h0001});
    send("lfsr_s0_1", {16'hB401, 16'hB400});
    send("lfsr_s0_2", {16'h5A01, 16'h5A00});

    // Pass-through and hold
    sr_write(SR_BASE, 32'd0);
    in_data = {16'hABCD, 16'h1234};
    send("pass0", {16'hABCD, 16'h1234});
    in_data = {16'h5555, 16'h6666};
    @(negedge clock);
    check_val("hold_out_data", 64'(out_data), 64'({16'hABCD, 16'h1234}));
    check_val("hold_out_strobe", 64'(out_strobe), 64'd0);

    // Reserved mode acts as pass-through, reads back as written
    sr_write(SR_BASE, 32'd5);
    check_val("mode_readback_5", 64'(mode), 64'd5);
    send("mode5_pass", {16'h5555, 16'h6666});

    // Writes outside the register window are ignored
    sr_write(SR_BASE + 7'd3, 32'd3);
    sr_write(SR_BASE - 7'd1, 32'd2);
    check_val("mode_after_foreign_write", 64'(mode), 64'd5);
    in_data = {16'h0F0F, 16'hF0F0};
    send("foreign_pass", {16'h0F0F, 16'hF0F0});

    // Reset mid-stream drops an in-flight strobe
    sr_write(SR_BASE, 32'd1);
    send("pre_reset_cnt", {16'h0001, 16'h0000});
    @(negedge clock);
    strobe = 1'b1;
    reset_n = 1'b0;
    @(negedge clock);
    strobe = 1'b0;
    check_val("midreset_out_data", 64'(out_data), 64'd0);
    check_val("midreset_out_strobe", 64'(out_strobe), 64'd0);
    check_val("midreset_mode", 64'(mode), 64'd0);
    reset_n = 1'b1;
    in_data = {16'hBEEF, 16'hCAFE};
    send("post_reset_pass", {16'hBEEF, 16'hCAFE});

    repeat (4) @(negedge clock);
    check_val("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, got timeout expected finish");
    $fatal(1);
  end

endmodule
